seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. Accepts one operation per start pulse, completes logic, add/sub, shift/rotate, negate, not and PC-increment in one cycle, and signed multiply and divide iteratively over W cycles. It reports completion with a start/busy/done handshake. It sits between the register-file read ports and the Z-register write path of the CPU datapath, where control can now wait on `done` instead of fixed delays.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_muldiv.sv | 81 ++++++++
 rtl/seq_alu.sv | 119 +++++++++++
 tb/tb_seq_alu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums plus the shift-amount mask helper.
// Used by seq_alu and its test bench; holds no logic of its own.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_ROR = 4'd8,
    OP_ROL = 4'd9,
    OP_NEG = 4'd10,
    OP_NOT = 4'd11,
    OP_INC = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } alu_state_t;

  // Shift/rotate amounts use only the low log2(width) bits of b.
  function automatic int unsigned rot_mask(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed multiply (radix-2 shift-add) and restoring divide on operand magnitudes, one bit per cycle.
// res is combinational and valid while last=1: it already folds in the final iteration and the sign fix-up.
module seq_muldiv #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic           mode,
  input  logic           run,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           last,
  output logic [2*W-1:0] res
);
  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc_q, acc_d, step, mul_nxt, div_nxt;
  logic [W-1:0]   opd_q, opd_d, mag_a, mag_b, quo, rem;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [W:0]     mul_sum, trial, diff;

  always_comb begin
    mag_a = a[W-1] ? -a : a;
    mag_b = b[W-1] ? -b : b;

    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_nxt = {mul_sum, acc_q[W-1:1]};

    // acc holds {remainder, dividend bits still to shift in / quotient bits so far}.
    trial   = acc_q[2*W-1:W-1];
    diff    = trial - {1'b0, opd_q};
    div_nxt = diff[W] ? {trial[W-1:0], acc_q[W-2:0], 1'b0}
                      : {diff[W-1:0],  acc_q[W-2:0], 1'b1};

    step = mode_q ? div_nxt : mul_nxt;
    rem  = neg_hi_q ? -step[2*W-1:W] : step[2*W-1:W];
    quo  = neg_lo_q ? -step[W-1:0]   : step[W-1:0];
    res  = mode_q ? {rem, quo} : (neg_lo_q ? -step : step);

    last = (cnt_q == CW'(W - 1));

    acc_d    = acc_q;
    opd_d    = opd_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (go) begin
      acc_d    = mode ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
      opd_d    = mode ? mag_b : mag_a;
      cnt_d    = '0;
      mode_d   = mode;
      neg_lo_d = a[W-1] ^ b[W-1];
      neg_hi_d = a[W-1];
    end else if (run) begin
      acc_d = step;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops complete with latency 1, MUL/DIV hold busy for W cycles then pulse done.
// No queuing: start is ignored while busy; it is accepted in IDLE and in the done (FINISH) cycle.
module seq_alu
  import alu_pkg::*;
#(
  parameter int W        = 32,
  parameter int INC_STEP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  alu_op_t        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           div_by_zero
);
  localparam logic [W-1:0] SH_MASK = W'(rot_mask(W));
  localparam logic [W-1:0] INC_W   = W'(INC_STEP);

  alu_state_t     state_q, state_d;
  logic [2*W-1:0] result_q, result_d, sc_res, md_res;
  logic           busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [W-1:0]   sh, sc_lo, ror_lo, rol_lo;
  logic           sc_sext, accept, iter, md_go, md_last;

  always_comb begin
    sh     = b & SH_MASK;
    ror_lo = W'({a, a} >> sh);
    rol_lo = W'(({a, a} << sh) >> W);
    sc_lo   = '0;
    sc_sext = 1'b0;
    case (op)
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_ADD: begin sc_lo = a + b; sc_sext = 1'b1; end
      OP_SUB: begin sc_lo = a - b; sc_sext = 1'b1; end
      OP_SHR: sc_lo = a >> sh;
      OP_SHL: sc_lo = a << sh;
      OP_ROR: sc_lo = ror_lo;
      OP_ROL: sc_lo = rol_lo;
      OP_NEG: begin sc_lo = -b; sc_sext = 1'b1; end
      OP_NOT: sc_lo = ~b;
      OP_INC: sc_lo = b + INC_W;
      default: sc_lo = '0;
    endcase
    sc_res = {{W{sc_sext & sc_lo[W-1]}}, sc_lo};
    // DIV only reaches the single-cycle path when b is zero.
    if (op == OP_DIV) sc_res = {a, {W{1'b1}}};
  end

  seq_muldiv #(.W(W)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (md_go),
    .mode  (op == OP_DIV),
    .run   (state_q == ST_RUN),
    .a     (a),
    .b     (b),
    .last  (md_last),
    .res   (md_res)
  );

  always_comb begin
    accept   = start && (state_q != ST_RUN);
    iter     = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    md_go    = 1'b0;
    state_d  = state_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_RUN: begin
        if (md_last) begin
          state_d  = ST_FINISH;
          result_d = md_res;
        end
      end
      default: begin
        if (accept && iter) begin
          state_d = ST_RUN;
          md_go   = 1'b1;
          dbz_d   = 1'b0;
        end else if (accept) begin
          state_d  = ST_FINISH;
          result_d = sc_res;
          dbz_d    = (op == OP_DIV);
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu at W=32 and W=8: opcode tables, MUL/DIV latency and sign cases,
// mid-run start rejection, reset abort during DIV, and back-to-back single-cycle issue.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start8 = 1'b0;
  alu_op_t     op = OP_AND, op8 = OP_AND;
  logic [31:0] a = '0, b = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy, done, dbz, busy8, done8, dbz8;
  logic [63:0] result;
  logic [15:0] result8;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.W(32), .INC_STEP(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .div_by_zero(dbz)
  );

  seq_alu #(.W(8), .INC_STEP(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .div_by_zero(dbz8)
  );

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dbz;
  } vec_t;

  typedef struct {
    alu_op_t     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
  } vec8_t;

  vec_t  vecs[16];
  vec8_t vecs8[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one MUL/DIV, optionally pulses start again at cycle `inject`, counts busy cycles
  // and reports the cycle (1 = first cycle after accept) in which done is seen.
  task automatic run_iter(input bit is8, input alu_op_t o, input logic [31:0] ia, input logic [31:0] ib,
                          input int inject, input logic [63:0] prev,
                          output int busy_n, output int done_at);
    busy_n  = 0;
    done_at = -1;
    if (is8) begin start8 = 1'b1; op8 = o; a8 = ia[7:0]; b8 = ib[7:0]; end
    else begin start = 1'b1; op = o; a = ia; b = ib; end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (is8) begin start8 = (c == inject); op8 = OP_OR; a8 = 8'h11; b8 = 8'h22; end
      else begin start = (c == inject); op = OP_ADD; a = 32'h1; b = 32'h1; end
      if (c == 4) chk($sformatf("%s hold mid-run", is8 ? "w8" : "w32"), is8 ? 64'(result8) : result, prev);
      if (is8 ? done8 : done) begin done_at = c; break; end
      if (is8 ? busy8 : busy) busy_n++;
    end
    start  = 1'b0;
    start8 = 1'b0;
  endtask

  int bn, da;

  initial begin
    vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 64'hFFFFFFFF_80000000, 1'b0};
    vecs[1]  = '{OP_SUB, 32'h00000000, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[2]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 1'b0};
    vecs[3]  = '{OP_OR,  32'h0F0F0000, 32'h000000F0, 64'h00000000_0F0F00F0, 1'b0};
    vecs[4]  = '{OP_SHR, 32'h80000000, 32'd31,       64'h00000000_00000001, 1'b0};
    vecs[5]  = '{OP_SHL, 32'h00000001, 32'd31,       64'h00000000_80000000, 1'b0};
    vecs[6]  = '{OP_ROR, 32'h80000001, 32'd36,       64'h00000000_18000000, 1'b0};
    vecs[7]  = '{OP_ROR, 32'h80000001, 32'd4,        64'h00000000_18000000, 1'b0};
    vecs[8]  = '{OP_ROL, 32'h12345678, 32'd0,        64'h00000000_12345678, 1'b0};
    vecs[9]  = '{OP_ROL, 32'h80000001, 32'd1,        64'h00000000_00000003, 1'b0};
    vecs[10] = '{OP_NEG, 32'h00000000, 32'd5,        64'hFFFFFFFF_FFFFFFFB, 1'b0};
    vecs[11] = '{OP_NOT, 32'h00000000, 32'h00000000, 64'h00000000_FFFFFFFF, 1'b0};
    vecs[12] = '{OP_INC, 32'h00000000, 32'h00000100, 64'h00000000_00000104, 1'b0};
    vecs[13] = '{alu_op_t'(4'd13), 32'hDEADBEEF, 32'h12345678, 64'h0, 1'b0};
    vecs[14] = '{OP_DIV, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 1'b1};
    vecs[15] = '{OP_ADD, 32'h00000005, 32'h00000003, 64'h00000000_00000008, 1'b0};

    vecs8[0] = '{OP_AND, 8'hF0, 8'h3C, 16'h0030};
    vecs8[1] = '{OP_OR,  8'hF0, 8'h0C, 16'h00FC};
    vecs8[2] = '{OP_AND, 8'hFF, 8'h81, 16'h0081};
    vecs8[3] = '{OP_OR,  8'h00, 8'h00, 16'h0000};
    vecs8[4] = '{OP_AND, 8'hAA, 8'h55, 16'h0000};
    vecs8[5] = '{OP_OR,  8'hAA, 8'h55, 16'h00FF};
    vecs8[6] = '{OP_ROR, 8'h81, 8'd9,  16'h00C0};
    vecs8[7] = '{OP_ADD, 8'h7F, 8'h01, 16'hFF80};

    // Reset state
    #22;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst dbz", 64'(dbz), 64'd0);
    chk("rst w8 result", 64'(result8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle table, issued back to back
    for (int i = 0; i < 16; i++) begin
      start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d done", i), 64'(done), 64'd1);
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d dbz", i), 64'(dbz), 64'(vecs[i].dbz));
    end
    start = 1'b0;
    @(negedge clk);
    chk("done one pulse", 64'(done), 64'd0);
    chk("result held idle", result, 64'h8);

    // MUL -3*7 with an ignored start mid-run
    run_iter(1'b0, OP_MUL, 32'hFFFFFFFD, 32'd7, 10, 64'h8, bn, da);
    chk("mul busy cycles", 64'(bn), 64'd32);
    chk("mul done cycle", 64'(da), 64'd33);
    chk("mul result", result, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);
    chk("mul no extra done", 64'(done), 64'd0);
    chk("mul result held", result, 64'hFFFFFFFF_FFFFFFEB);

    run_iter(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 64'hFFFFFFFF_FFFFFFEB, bn, da);
    chk("div -7/2 done cycle", 64'(da), 64'd33);
    chk("div -7/2 result", result, 64'hFFFFFFFF_FFFFFFFD);
    run_iter(1'b0, OP_DIV, 32'd7, 32'hFFFFFFFE, 0, 64'hFFFFFFFF_FFFFFFFD, bn, da);
    chk("div 7/-2 result", result, 64'h00000001_FFFFFFFD);
    run_iter(1'b0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 64'h00000001_FFFFFFFD, bn, da);
    chk("div minneg/-1 result", result, 64'h00000000_80000000);
    chk("div minneg/-1 dbz", 64'(dbz), 64'd0);
    run_iter(1'b0, OP_MUL, 32'h80000000, 32'hFFFFFFFF, 0, 64'h00000000_80000000, bn, da);
    chk("mul minneg*-1 result", result, 64'h00000000_80000000);
    @(negedge clk);

    // Reset in cycle 10 of a DIV
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort result", result, 64'd0);
    chk("abort dbz", 64'(dbz), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("in reset done c%0d", c), 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) chk("no done after abort", 64'(done), 64'd0);
    end
    start = 1'b1; op = OP_INC; a = 32'hFFFFFFFF; b = 32'h100;
    @(negedge clk);
    start = 1'b0;
    chk("inc after reset done", 64'(done), 64'd1);
    chk("inc after reset result", result, 64'h104);

    // W=8 instance
    run_iter(1'b1, OP_MUL, 32'h80, 32'h80, 0, 64'h0, bn, da);
    chk("w8 mul busy cycles", 64'(bn), 64'd8);
    chk("w8 mul done cycle", 64'(da), 64'd9);
    chk("w8 mul result", 64'(result8), 64'h4000);
    for (int i = 0; i < 8; i++) begin
      start8 = 1'b1; op8 = vecs8[i].op; a8 = vecs8[i].a; b8 = vecs8[i].b;
      @(negedge clk);
      chk($sformatf("w8 vec%0d done", i), 64'(done8), 64'd1);
      chk($sformatf("w8 vec%0d result", i), 64'(result8), 64'(vecs8[i].res));
    end
    start8 = 1'b0;
    @(negedge clk);
    chk("w8 done drops", 64'(done8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
